// File: rtl/mem_sweep_pkg.sv
// Shared types and constants for the board-memory sweep scheduler.
package mem_sweep_pkg;

    localparam int DEF_NCELLS = 256;
    localparam int DEF_ADDR_W = 9;

    // Request vector bit positions; a lower index wins when several are raised together.
    localparam int PRI_LOAD  = 0;
    localparam int PRI_WRITE = 1;
    localparam int PRI_READ  = 2;
    localparam int PRI_OUT   = 3;
    localparam int NUM_REQ   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_READ,
        ST_OUT,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic state_t pick_sweep(input logic [NUM_REQ-1:0] req);
        state_t sel;
        sel = ST_IDLE;
        if (req[PRI_LOAD])
            sel = ST_LOAD;
        else if (req[PRI_WRITE])
            sel = ST_WRITE;
        else if (req[PRI_READ])
            sel = ST_READ;
        else if (req[PRI_OUT])
            sel = ST_OUT;
        return sel;
    endfunction

endpackage

// File: rtl/sweep_counter.sv
// Cell address counter for one sweep; saturates at the last cell instead of wrapping.
module sweep_counter #(
    parameter int NCELLS = 256,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NCELLS - 1);

    logic [ADDR_W-1:0] addr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            addr_reg <= '0;
        else if (clear)
            addr_reg <= '0;
        else if (enable && !last)
            addr_reg <= addr_reg + 1'b1;
    end

    assign addr = addr_reg;
    assign last = (addr_reg == LAST_ADDR);

endmodule

// File: rtl/mem_sweep_sched.sv
// Sequences LOAD / WRITE / READ / OUT sweeps over the cell RAM and tracks the live-cell count.
module mem_sweep_sched
    import mem_sweep_pkg::*;
#(
    parameter int NCELLS = DEF_NCELLS,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clka,
    input  logic              reset,
    input  logic              load_req,
    input  logic              read_req,
    input  logic              write_req,
    input  logic              out_req,
    input  logic              abort,
    input  logic              ser_in,
    input  logic              cell_next,
    input  logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_wd,
    output logic              rd_valid,
    output logic              rd_bit,
    output logic              ser_valid,
    output logic              ser_out,
    output logic              busy,
    output logic              done,
    output logic [8:0]        alive_cnt,
    output logic              all_dead
);

    state_t state_reg, state_next;

    logic [NUM_REQ-1:0] req_vec;
    logic               cnt_clear;
    logic               cnt_enable;
    logic               cnt_last;
    logic               beat_reg;
    logic               beat_out_reg;
    logic [8:0]         acc_reg;
    logic [8:0]         acc_next;
    logic [8:0]         alive_reg;
    logic               all_dead_reg;

    sweep_counter #(
        .NCELLS (NCELLS),
        .ADDR_W (ADDR_W)
    ) u_counter (
        .clk    (clka),
        .rst    (reset),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .addr   (mem_addr),
        .last   (cnt_last)
    );

    always_comb begin
        req_vec            = '0;
        req_vec[PRI_LOAD]  = load_req;
        req_vec[PRI_WRITE] = write_req;
        req_vec[PRI_READ]  = read_req;
        req_vec[PRI_OUT]   = out_req;
    end

    always_ff @(posedge clka or posedge reset) begin
        if (reset)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;
        mem_we     = 1'b0;
        mem_wd     = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                busy       = 1'b0;
                cnt_clear  = 1'b1;
                state_next = pick_sweep(req_vec);
            end
            ST_LOAD: begin
                mem_we     = 1'b1;
                mem_wd     = ser_in;
                cnt_enable = 1'b1;
                if (cnt_last)
                    state_next = ST_DONE;
            end
            ST_WRITE: begin
                mem_we     = 1'b1;
                mem_wd     = cell_next;
                cnt_enable = 1'b1;
                if (cnt_last)
                    state_next = ST_DONE;
            end
            ST_READ, ST_OUT: begin
                cnt_enable = 1'b1;
                if (cnt_last)
                    state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                cnt_clear  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        // Abort overrides everything, including a request seen in IDLE.
        if (abort) begin
            state_next = ST_IDLE;
            cnt_clear  = 1'b1;
        end
    end

    assign acc_next = acc_reg + {8'd0, cell_next};

    // RAM read data lags the address by one cycle, so the beat flag is a delayed copy of the sweep.
    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            beat_reg     <= 1'b0;
            beat_out_reg <= 1'b0;
        end else begin
            beat_reg <= !abort && (state_reg == ST_READ || state_reg == ST_OUT);
            if (state_reg == ST_READ)
                beat_out_reg <= 1'b0;
            else if (state_reg == ST_OUT)
                beat_out_reg <= 1'b1;
        end
    end

    // Live cells accumulate privately and are published only when a WRITE sweep completes.
    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            acc_reg      <= '0;
            alive_reg    <= '0;
            all_dead_reg <= 1'b1;
        end else begin
            if (state_reg == ST_IDLE)
                acc_reg <= '0;
            else if (state_reg == ST_WRITE)
                acc_reg <= acc_next;
            if (state_reg == ST_WRITE && cnt_last && !abort) begin
                alive_reg    <= acc_next;
                all_dead_reg <= (acc_next == 9'd0);
            end
        end
    end

    assign rd_valid  = beat_reg && !beat_out_reg;
    assign rd_bit    = rd_valid && mem_rd;
    assign ser_valid = beat_reg && beat_out_reg;
    assign ser_out   = ser_valid && mem_rd;
    assign alive_cnt = alive_reg;
    assign all_dead  = all_dead_reg;

endmodule

// File: tb/tb_mem_sweep_sched.sv
// Scoreboard bench for mem_sweep_sched with a behavioural single-bit RAM.
module tb_mem_sweep_sched;

    localparam int N = 256;

    logic clka = 1'b0;
    logic reset = 1'b1;
    logic load_req = 1'b0;
    logic read_req = 1'b0;
    logic write_req = 1'b0;
    logic out_req = 1'b0;
    logic abort = 1'b0;
    logic ser_in = 1'b0;
    logic cell_next = 1'b0;
    logic mem_rd = 1'b0;

    logic [8:0] mem_addr;
    logic       mem_we;
    logic       mem_wd;
    logic       rd_valid;
    logic       rd_bit;
    logic       ser_valid;
    logic       ser_out;
    logic       busy;
    logic       done;
    logic [8:0] alive_cnt;
    logic       all_dead;

    int checks = 0;
    int passed = 0;
    int model_alive = 0;

    logic ram [0:N-1];
    logic pat [0:N-1];
    logic [8:0] exp_addr_q[$];
    logic       exp_bit_q[$];

    mem_sweep_sched #(.NCELLS(N), .ADDR_W(9)) dut (
        .clka      (clka),
        .reset     (reset),
        .load_req  (load_req),
        .read_req  (read_req),
        .write_req (write_req),
        .out_req   (out_req),
        .abort     (abort),
        .ser_in    (ser_in),
        .cell_next (cell_next),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wd    (mem_wd),
        .rd_valid  (rd_valid),
        .rd_bit    (rd_bit),
        .ser_valid (ser_valid),
        .ser_out   (ser_out),
        .busy      (busy),
        .done      (done),
        .alive_cnt (alive_cnt),
        .all_dead  (all_dead)
    );

    always #5 clka = ~clka;

    always @(posedge clka) begin
        if (mem_we)
            ram[mem_addr] <= mem_wd;
        mem_rd <= ram[mem_addr];
    end

    task automatic test_reset();
        logic [26:0] obs;
        load_req = 1'b1;
        @(posedge clka); #1;
        @(posedge clka); #1;
        obs = {mem_addr, mem_we, mem_wd, rd_valid, rd_bit, ser_valid, ser_out,
               busy, done, alive_cnt, all_dead};
        checks++;
        if (obs !== 27'd1) $display("FAIL reset_values got %b want %b", obs, 27'd1);
        else passed++;
        load_req = 1'b0;
        reset = 1'b0;
        @(posedge clka); #1;
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_no_queue busy got %b want 0", busy);
        else passed++;
        $display("txn reset: checked reset values and idle after release");
    endtask

    task automatic test_write_sweep(input string name, input bit is_load, input bit all_req,
                                    input int read_mid);
        int         writes;
        int         done_at;
        int         exp_alive;
        logic [8:0] alive_seen;
        logic       dead_seen;
        logic [8:0] ea;
        logic       eb;
        writes = 0;
        done_at = -1;
        exp_alive = 0;
        alive_seen = '0;
        dead_seen = 1'b0;
        for (int k = 0; k < N; k++) exp_alive += int'(pat[k]);
        load_req  = is_load || all_req;
        write_req = !is_load || all_req;
        out_req   = all_req;
        @(posedge clka); #1;
        load_req = 1'b0;
        write_req = 1'b0;
        out_req = 1'b0;
        for (int j = 0; j < N + 4; j++) begin
            if (j < N) begin
                ser_in    = is_load ? pat[j] : ~pat[j];
                cell_next = is_load ? ~pat[j] : pat[j];
                exp_addr_q.push_back(9'(j));
                exp_bit_q.push_back(pat[j]);
            end else begin
                ser_in = 1'b0;
                cell_next = 1'b0;
            end
            read_req = (j == read_mid);
            @(negedge clka);
            if (mem_we) begin
                writes++;
                checks++;
                if (exp_addr_q.size() == 0) begin
                    $display("FAIL %s extra_write addr got %0d want none", name, mem_addr);
                end else begin
                    ea = exp_addr_q.pop_front();
                    eb = exp_bit_q.pop_front();
                    if ({mem_addr, mem_wd} !== {ea, eb})
                        $display("FAIL %s write addr/data got %0d/%b want %0d/%b",
                                 name, mem_addr, mem_wd, ea, eb);
                    else passed++;
                end
            end
            if (done) begin
                if (done_at < 0) begin
                    done_at = j;
                    alive_seen = alive_cnt;
                    dead_seen = all_dead;
                end else begin
                    done_at = -2;
                end
            end
            @(posedge clka); #1;
        end
        read_req = 1'b0;
        checks++;
        if (writes !== N) $display("FAIL %s write_count got %0d want %0d", name, writes, N);
        else passed++;
        checks++;
        if (done_at !== N) $display("FAIL %s done_cycle got %0d want %0d", name, done_at, N);
        else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL %s busy_after got %b want 0", name, busy);
        else passed++;
        if (!is_load) begin
            checks++;
            if (alive_seen !== 9'(exp_alive))
                $display("FAIL %s alive_cnt got %0d want %0d", name, alive_seen, exp_alive);
            else passed++;
            checks++;
            if (dead_seen !== (exp_alive == 0))
                $display("FAIL %s all_dead got %b want %b", name, dead_seen, exp_alive == 0);
            else passed++;
            model_alive = exp_alive;
        end
        exp_addr_q.delete();
        exp_bit_q.delete();
        $display("txn %s: writes=%0d done_at=%0d alive_expected=%0d", name, writes, done_at, exp_alive);
    endtask

    task automatic test_abort();
        logic [8:0] ea;
        logic       eb;
        logic       done_seen;
        logic       busy_seen;
        done_seen = 1'b0;
        busy_seen = 1'b0;
        write_req = 1'b1;
        @(posedge clka); #1;
        write_req = 1'b0;
        for (int j = 0; j <= 100; j++) begin
            cell_next = pat[j];
            exp_addr_q.push_back(9'(j));
            exp_bit_q.push_back(pat[j]);
            abort = (j == 100);
            @(negedge clka);
            ea = exp_addr_q.pop_front();
            eb = exp_bit_q.pop_front();
            checks++;
            if ({mem_we, mem_addr, mem_wd} !== {1'b1, ea, eb})
                $display("FAIL abort_sweep we/addr/data got %b/%0d/%b want 1/%0d/%b",
                         mem_we, mem_addr, mem_wd, ea, eb);
            else passed++;
            @(posedge clka); #1;
        end
        abort = 1'b0;
        cell_next = 1'b0;
        @(negedge clka);
        checks++;
        if ({busy, mem_we, done, mem_addr} !== 12'd0)
            $display("FAIL abort_idle busy/we/done/addr got %b/%b/%b/%0d want 0/0/0/0",
                     busy, mem_we, done, mem_addr);
        else passed++;
        checks++;
        if (alive_cnt !== 9'(model_alive))
            $display("FAIL abort_alive got %0d want %0d", alive_cnt, model_alive);
        else passed++;
        checks++;
        if (all_dead !== (model_alive == 0))
            $display("FAIL abort_all_dead got %b want %b", all_dead, model_alive == 0);
        else passed++;
        for (int j = 0; j < N + 4; j++) begin
            @(negedge clka);
            done_seen |= done;
            busy_seen |= busy;
        end
        checks++;
        if ({done_seen, busy_seen} !== 2'b00)
            $display("FAIL abort_quiet done/busy got %b/%b want 0/0", done_seen, busy_seen);
        else passed++;
        exp_addr_q.delete();
        exp_bit_q.delete();
        @(posedge clka); #1;
        $display("txn abort: write aborted at address 100, alive kept at %0d", model_alive);
    endtask

    task automatic test_read_out(input string name, input bit is_out, input int reset_at);
        int          beats;
        int          last_beat;
        int          done_at;
        int          stray;
        logic        v;
        logic        b;
        logic        eb;
        logic [26:0] obs;
        beats = 0;
        last_beat = -1;
        done_at = -1;
        stray = 0;
        for (int k = 0; k < N; k++) exp_bit_q.push_back(pat[k]);
        read_req = !is_out;
        out_req = is_out;
        @(posedge clka); #1;
        read_req = 1'b0;
        out_req = 1'b0;
        for (int j = 0; j < N + 4; j++) begin
            @(negedge clka);
            if (mem_we) stray++;
            if (is_out ? rd_valid : ser_valid) stray++;
            v = is_out ? ser_valid : rd_valid;
            b = is_out ? ser_out : rd_bit;
            if (v) begin
                beats++;
                last_beat = j;
                checks++;
                if (exp_bit_q.size() == 0) begin
                    $display("FAIL %s extra_beat got %b want none", name, b);
                end else begin
                    eb = exp_bit_q.pop_front();
                    if (b !== eb) $display("FAIL %s beat %0d got %b want %b", name, beats - 1, b, eb);
                    else passed++;
                end
            end
            if (done && done_at < 0) done_at = j;
            if (j == reset_at) begin
                checks++;
                if (mem_addr !== 9'(j)) $display("FAIL %s addr_before_reset got %0d want %0d", name, mem_addr, j);
                else passed++;
                #2 reset = 1'b1;
                #1;
                obs = {mem_addr, mem_we, mem_wd, rd_valid, rd_bit, ser_valid, ser_out,
                       busy, done, alive_cnt, all_dead};
                checks++;
                if (obs !== 27'd1) $display("FAIL %s async_reset got %b want %b", name, obs, 27'd1);
                else passed++;
                @(posedge clka); #1;
                reset = 1'b0;
                exp_bit_q.delete();
                $display("txn %s: async reset at address %0d after %0d beats", name, j, beats);
                return;
            end
            @(posedge clka); #1;
        end
        checks++;
        if (beats !== N) $display("FAIL %s beat_count got %0d want %0d", name, beats, N);
        else passed++;
        checks++;
        if (last_beat !== N) $display("FAIL %s last_beat got %0d want %0d", name, last_beat, N);
        else passed++;
        checks++;
        if (done_at !== N + 1) $display("FAIL %s done_cycle got %0d want %0d", name, done_at, N + 1);
        else passed++;
        checks++;
        if (stray !== 0) $display("FAIL %s stray_outputs got %0d want 0", name, stray);
        else passed++;
        exp_bit_q.delete();
        $display("txn %s: beats=%0d done_at=%0d", name, beats, done_at);
    endtask

    initial begin
        for (int k = 0; k < N; k++) ram[k] = 1'b0;
        test_reset();

        for (int k = 0; k < N; k++) pat[k] = (k % 2 == 0);
        test_write_sweep("load_alt", 1'b1, 1'b0, -1);

        for (int k = 0; k < N; k++) pat[k] = 1'($urandom_range(1, 0));
        test_write_sweep("priority_all_req", 1'b1, 1'b1, 40);

        for (int k = 0; k < N; k++) pat[k] = 1'b0;
        pat[3] = 1'b1; pat[77] = 1'b1; pat[128] = 1'b1; pat[200] = 1'b1; pat[255] = 1'b1;
        test_write_sweep("write_five", 1'b0, 1'b0, -1);

        for (int k = 0; k < N; k++) pat[k] = 1'b0;
        test_write_sweep("write_zero", 1'b0, 1'b0, -1);

        pat[0] = 1'b1; pat[50] = 1'b1; pat[99] = 1'b1; pat[180] = 1'b1; pat[254] = 1'b1;
        test_write_sweep("write_five_b", 1'b0, 1'b0, -1);

        for (int k = 0; k < N; k++) pat[k] = 1'b1;
        test_abort();

        for (int k = 0; k < N; k++) pat[k] = 1'($urandom_range(1, 0));
        test_write_sweep("load_rand", 1'b1, 1'b0, -1);
        test_read_out("read", 1'b0, -1);
        test_read_out("out_reset", 1'b1, 50);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
